// File: rtl/global_defs.sv
// Project-wide default sizes for the MPU datapath.
// Modules take these as parameter defaults so a single edit resizes the MPU.
package global_defs;

  localparam int DEF_FP              = 32;
  localparam int DEF_M               = 4;
  localparam int DEF_N               = 4;
  localparam int DEF_MATRIX_REG_SIZE = 2;

endpackage

// File: rtl/mpu_pkg.sv
// Shared types and helpers for the MPU matrix loader.
package mpu_pkg;

  typedef enum logic [1:0] {
    LOAD_IDLE   = 2'd0,
    LOAD_ACTIVE = 2'd1,
    LOAD_DONE   = 2'd2
  } load_stream_state_t;

  // A requested matrix is loadable when both dimensions are non-zero
  // and neither exceeds the register-file matrix limits.
  function automatic logic dims_ok(input int unsigned mSize,
                                   input int unsigned nSize,
                                   input int unsigned maxM,
                                   input int unsigned maxN);
    return (mSize != 0) && (nSize != 0) && (mSize <= maxM) && (nSize <= maxN);
  endfunction

endpackage

// File: rtl/mpu_load_addr_gen.sv
// Row/column pointer walk for the streaming matrix loader.
// Produces the (row, col) of lane 0, the lane mask of the current beat and a
// flag marking the final beat. Row-major walks columns within a row; with the
// transpose flag latched, lanes span rows and the walk is column-major.
module mpu_load_addr_gen #(
  parameter int MBITS = 2,
  parameter int NBITS = 2,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init,
  input  logic             i_step,
  input  logic [MBITS:0]   i_mSize,
  input  logic [NBITS:0]   i_nSize,
  input  logic             i_transpose,
  output logic [MBITS:0]   o_row,
  output logic [NBITS:0]   o_col,
  output logic [LANES-1:0] o_mask,
  output logic             o_last
);

  // One extra bit on the pointer sums so pointer+LANES never wraps.
  localparam int RW = MBITS + 2;
  localparam int CW = NBITS + 2;

  logic [MBITS:0] r_row;
  logic [NBITS:0] r_col;
  logic [MBITS:0] r_mSize;
  logic [NBITS:0] r_nSize;
  logic           r_transpose;

  logic [CW-1:0]  w_colNext;
  logic [RW-1:0]  w_rowNext;
  logic           w_rowEnd;
  logic           w_colEnd;
  logic           w_lastRow;
  logic           w_lastCol;

  assign w_colNext = {1'b0, r_col} + CW'(LANES);
  assign w_rowNext = {1'b0, r_row} + RW'(LANES);
  assign w_rowEnd  = w_colNext >= {1'b0, r_nSize};
  assign w_colEnd  = w_rowNext >= {1'b0, r_mSize};
  assign w_lastRow = r_row == (r_mSize - (MBITS+1)'(1));
  assign w_lastCol = r_col == (r_nSize - (NBITS+1)'(1));

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = r_transpose ? (w_lastCol && w_colEnd) : (w_lastRow && w_rowEnd);

  // Lane i is valid while it still lies inside the matrix along the lane axis.
  always_comb begin
    o_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_transpose) begin
        o_mask[i] = ({1'b0, r_row} + RW'(i)) < {1'b0, r_mSize};
      end else begin
        o_mask[i] = ({1'b0, r_col} + CW'(i)) < {1'b0, r_nSize};
      end
    end
  end

  // Latch sizes on a new load, then advance one beat per accepted transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row       <= '0;
      r_col       <= '0;
      r_mSize     <= '0;
      r_nSize     <= '0;
      r_transpose <= 1'b0;
    end else if (i_init) begin
      r_row       <= '0;
      r_col       <= '0;
      r_mSize     <= i_mSize;
      r_nSize     <= i_nSize;
      r_transpose <= i_transpose;
    end else if (i_step) begin
      if (r_transpose) begin
        if (w_colEnd) begin
          r_row <= '0;
          r_col <= r_col + (NBITS+1)'(1);
        end else begin
          r_row <= w_rowNext[MBITS:0];
        end
      end else begin
        if (w_rowEnd) begin
          r_col <= '0;
          r_row <= r_row + (MBITS+1)'(1);
        end else begin
          r_col <= w_colNext[NBITS:0];
        end
      end
    end
  end

endmodule

// File: rtl/mpu_load_stream.sv
// Streaming matrix loader: accepts up to LANES elements per valid/ready beat
// and issues lane-masked writes into the matrix register file.
// Optional feature macro: MPU_LOAD_TRANSPOSE_EN adds a 'transpose' input that
// selects a column-major input stream; without it the stream is row-major.
module mpu_load_stream
  import mpu_pkg::*;
#(
  parameter int FP              = global_defs::DEF_FP,
  parameter int M               = global_defs::DEF_M,
  parameter int N               = global_defs::DEF_N,
  parameter int LANES           = 1,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_SIZE = global_defs::DEF_MATRIX_REG_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MBITS:0]             matrix_m_size,
  input  logic [NBITS:0]             matrix_n_size,
  input  logic [MATRIX_REG_SIZE-1:0] load_addr,
`ifdef MPU_LOAD_TRANSPOSE_EN
  input  logic                       transpose,
`endif
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [LANES*FP-1:0]        in_data,
  output logic                       in_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       write_en,
  output logic [MATRIX_REG_SIZE-1:0] reg_load_addr,
  output logic [LANES*FP-1:0]        element_out,
  output logic [LANES-1:0]           lane_mask,
  output logic [MBITS:0]             m,
  output logic [NBITS:0]             n
);

  load_stream_state_t r_state;
  load_stream_state_t w_nextState;

  logic             w_dimsOk;
  logic             w_init;
  logic             w_step;
  logic             w_transpose;
  logic [MBITS:0]   w_row;
  logic [NBITS:0]   w_col;
  logic [LANES-1:0] w_mask;
  logic             w_last;

  assign w_dimsOk = dims_ok(32'(matrix_m_size), 32'(matrix_n_size), 32'(M), 32'(N));

`ifdef MPU_LOAD_TRANSPOSE_EN
  assign w_transpose = transpose;
`else
  assign w_transpose = 1'b0;
`endif

  mpu_load_addr_gen #(
    .MBITS (MBITS),
    .NBITS (NBITS),
    .LANES (LANES)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_init      (w_init),
    .i_step      (w_step),
    .i_mSize     (matrix_m_size),
    .i_nSize     (matrix_n_size),
    .i_transpose (w_transpose),
    .o_row       (w_row),
    .o_col       (w_col),
    .o_mask      (w_mask),
    .o_last      (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state; abort beats any beat offered in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_init      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      LOAD_IDLE: begin
        if (start && w_dimsOk) begin
          w_init      = 1'b1;
          w_nextState = LOAD_ACTIVE;
        end
      end
      LOAD_ACTIVE: begin
        if (abort) begin
          w_nextState = LOAD_IDLE;
        end else if (in_valid && in_ready) begin
          w_step = 1'b1;
          if (w_last) begin
            w_nextState = LOAD_DONE;
          end
        end
      end
      LOAD_DONE: begin
        w_nextState = LOAD_IDLE;
      end
      default: begin
        w_nextState = LOAD_IDLE;
      end
    endcase
  end

  // Registered outputs: write one cycle after acceptance, done one after the last write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      write_en      <= 1'b0;
      reg_load_addr <= '0;
      element_out   <= '0;
      lane_mask     <= '0;
      m             <= '0;
      n             <= '0;
    end else begin
      in_ready <= (w_nextState == LOAD_ACTIVE);
      busy     <= (w_nextState == LOAD_ACTIVE);
      done     <= (r_state == LOAD_DONE);
      write_en <= w_step;
      if (w_step) begin
        element_out <= in_data;
        lane_mask   <= w_mask;
        m           <= w_row;
        n           <= w_col;
      end
      if ((r_state == LOAD_IDLE) && start) begin
        error <= !w_dimsOk;
      end
      if (w_init) begin
        reg_load_addr <= load_addr;
      end
    end
  end

endmodule
